// File: rtl/debouncer_multi.sv
// Multi-channel button debouncer: shared sample-tick divider, per-channel 2-flop
// synchronizer, and a consecutive-disagreement counter that flips the debounced level.
module debouncer_multi #(
    parameter int N         = 4,
    parameter int CLK_HZ    = 50_000_000,
    parameter int SAMPLE_HZ = 1000,
    parameter int STABLE    = 4,
    parameter bit IN_INV    = 1'b0
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         en,
    input  logic [N-1:0] btn_in,
    output logic [N-1:0] btn_level,
    output logic [N-1:0] btn_rise,
    output logic [N-1:0] btn_fall
);

    localparam int DIV = CLK_HZ / SAMPLE_HZ;
    localparam int DW  = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int SW  = (STABLE >= 1) ? $clog2(STABLE + 1) : 1;

    localparam logic [DW-1:0] DIV_LAST = DW'(DIV - 1);
    localparam logic [SW-1:0] CNT_LAST = SW'(STABLE - 1);

    if (DIV < 2 || STABLE < 1) begin : g_bad_params
        $error("debouncer_multi: CLK_HZ/SAMPLE_HZ must be >= 2 and STABLE must be >= 1");
    end

    logic [DW-1:0] div_cnt;
    logic          tick;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            div_cnt <= '0;
        end else if (!en || div_cnt == DIV_LAST) begin
            div_cnt <= '0;
        end else begin
            div_cnt <= div_cnt + DW'(1);
        end
    end

    assign tick = en && (div_cnt == DIV_LAST);

    // Synchronizer resets to the idle input level so an active-low idle input
    // does not look like a press right after reset.
    logic [N-1:0] sync1;
    logic [N-1:0] sync2;
    logic [N-1:0] sample;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync1 <= {N{IN_INV}};
            sync2 <= {N{IN_INV}};
        end else begin
            sync1 <= btn_in;
            sync2 <= sync1;
        end
    end

    assign sample = sync2 ^ {N{IN_INV}};

    for (genvar i = 0; i < N; i++) begin : g_ch
        logic [SW-1:0] cnt;
        logic          level;
        logic          rise;
        logic          fall;
        logic          disagree;
        logic          flip;

        assign disagree = sample[i] ^ level;
        assign flip     = tick && disagree && (cnt == CNT_LAST);

        // Pulses are registered alongside the level so they coincide with its change.
        always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
                cnt   <= '0;
                level <= 1'b0;
                rise  <= 1'b0;
                fall  <= 1'b0;
            end else begin
                rise <= flip && !level;
                fall <= flip && level;
                if (tick) begin
                    if (!disagree || cnt == CNT_LAST) begin
                        cnt <= '0;
                    end else begin
                        cnt <= cnt + SW'(1);
                    end
                    if (flip) begin
                        level <= ~level;
                    end
                end
            end
        end

        assign btn_level[i] = level;
        assign btn_rise[i]  = rise;
        assign btn_fall[i]  = fall;
    end

endmodule

// File: tb/tb_debouncer_multi.sv
// Scoreboard bench for debouncer_multi: a run-length reference model predicts pulse
// events into queues, a monitor pops and compares them as the DUTs emit pulses.
module tb_debouncer_multi;

    localparam int N         = 2;
    localparam int CLK_HZ    = 100;
    localparam int SAMPLE_HZ = 10;
    localparam int STABLE    = 3;
    localparam int DIV       = CLK_HZ / SAMPLE_HZ;
    localparam int W         = 32 + 3 * N;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic         en  = 1'b1;
    logic [N-1:0] b0  = '0;
    logic [N-1:0] b1  = '1;
    logic [N-1:0] lvl0, rise0, fall0;
    logic [N-1:0] lvl1, rise1, fall1;

    always #5 clk = ~clk;

    debouncer_multi #(.N(N), .CLK_HZ(CLK_HZ), .SAMPLE_HZ(SAMPLE_HZ), .STABLE(STABLE), .IN_INV(1'b0)) dut0 (
        .clk(clk), .rst(rst), .en(en), .btn_in(b0),
        .btn_level(lvl0), .btn_rise(rise0), .btn_fall(fall0)
    );

    debouncer_multi #(.N(N), .CLK_HZ(CLK_HZ), .SAMPLE_HZ(SAMPLE_HZ), .STABLE(STABLE), .IN_INV(1'b1)) dut1 (
        .clk(clk), .rst(rst), .en(en), .btn_in(b1),
        .btn_level(lvl1), .btn_rise(rise1), .btn_fall(fall1)
    );

    int unsigned  n_cmp = 0;
    int unsigned  n_err = 0;
    int unsigned  cyc   = 0;

    // Scoreboard records: {cycle, level, rise, fall}
    logic [W-1:0] exp_q0[$];
    logic [W-1:0] exp_q1[$];

    // Reference model state
    int           phase;
    logic [N-1:0] h1[2];
    logic [N-1:0] h2[2];
    logic [N-1:0] mlev[2];
    int           run[2][N];

    // Monitor statistics for directed checks
    int unsigned  pulses0 = 0, pulses1 = 0;
    int unsigned  rise_cnt0 = 0, fall_cnt0 = 0;
    int unsigned  last_rise_cyc0 = 0;
    logic [N-1:0] last_rise_vec0 = '0, last_rise_vec1 = '0;

    function automatic logic [N-1:0] inv_of(input int k);
        return (k == 0) ? {N{1'b0}} : {N{1'b1}};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic check_range(input string name, input int unsigned act, input int unsigned lo, input int unsigned hi);
        n_cmp++;
        if (act < lo || act > hi) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d..%0d (cycle %0d)", name, act, lo, hi, cyc);
        end
    endtask

    task automatic fail(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        n_err++;
        $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    endtask

    // Reference model: a channel flips after STABLE consecutive tick samples that
    // disagree with its level; the sample seen at a tick is btn_in from two edges back.
    always @(posedge clk) begin
        logic         tk;
        logic [N-1:0] s;
        logic [N-1:0] rs_v;
        logic [N-1:0] fa_v;
        cyc++;
        if (!rst) begin
            phase = 0;
            for (int k = 0; k < 2; k++) begin
                h1[k]   = inv_of(k);
                h2[k]   = inv_of(k);
                mlev[k] = '0;
                for (int c = 0; c < N; c++) run[k][c] = 0;
            end
        end else begin
            tk = 1'b0;
            if (!en) phase = 0;
            else if (phase == DIV - 1) begin
                tk    = 1'b1;
                phase = 0;
            end else phase++;
            for (int k = 0; k < 2; k++) begin
                s    = h2[k] ^ inv_of(k);
                rs_v = '0;
                fa_v = '0;
                if (tk) begin
                    for (int c = 0; c < N; c++) begin
                        if (s[c] != mlev[k][c]) run[k][c]++;
                        else run[k][c] = 0;
                        if (run[k][c] == STABLE) begin
                            run[k][c] = 0;
                            if (mlev[k][c]) fa_v[c] = 1'b1;
                            else rs_v[c] = 1'b1;
                            mlev[k][c] = ~mlev[k][c];
                        end
                    end
                end
                if ((rs_v | fa_v) != '0) begin
                    if (k == 0) exp_q0.push_back({cyc, mlev[k], rs_v, fa_v});
                    else exp_q1.push_back({cyc, mlev[k], rs_v, fa_v});
                end
                h2[k] = h1[k];
                h1[k] = (k == 0) ? b0 : b1;
            end
        end
    end

    function automatic int q_size(input int k);
        return (k == 0) ? exp_q0.size() : exp_q1.size();
    endfunction

    function automatic logic [W-1:0] q_front(input int k);
        return (k == 0) ? exp_q0[0] : exp_q1[0];
    endfunction

    function automatic logic [W-1:0] q_pop(input int k);
        if (k == 0) return exp_q0.pop_front();
        return exp_q1.pop_front();
    endfunction

    task automatic mon(input int k, input logic [N-1:0] lv, input logic [N-1:0] rs, input logic [N-1:0] fl);
        logic [W-1:0] e;
        logic [31:0]  ecyc;
        if (!rst) begin
            check($sformatf("reset_outputs_zero%0d", k), {26'd0, lv, rs, fl}, 32'd0);
            return;
        end
        check($sformatf("rise_fall_exclusive%0d", k), {30'd0, rs & fl}, 32'd0);
        check($sformatf("level%0d", k), {30'd0, lv}, {30'd0, mlev[k]});
        while (q_size(k) > 0) begin
            e    = q_front(k);
            ecyc = e[W-1 -: 32];
            if (ecyc >= cyc) break;
            e = q_pop(k);
            fail($sformatf("missing_pulse%0d", k), 32'd0, {26'd0, e[3*N-1:0]});
        end
        if ((rs | fl) != '0) begin
            if (q_size(k) == 0) begin
                fail($sformatf("unexpected_pulse%0d", k), {26'd0, lv, rs, fl}, 32'd0);
            end else begin
                e    = q_front(k);
                ecyc = e[W-1 -: 32];
                if (ecyc != cyc) begin
                    fail($sformatf("unexpected_pulse%0d", k), {26'd0, lv, rs, fl}, 32'd0);
                end else begin
                    e = q_pop(k);
                    check($sformatf("pulse%0d", k), {26'd0, lv, rs, fl}, {26'd0, e[3*N-1:0]});
                end
            end
            if (k == 0) begin
                pulses0++;
                if (rs[0]) begin
                    rise_cnt0++;
                    last_rise_cyc0 = cyc;
                end
                if (fl[0]) fall_cnt0++;
                if (rs != '0) last_rise_vec0 = rs;
            end else begin
                pulses1++;
                if (rs != '0) last_rise_vec1 = rs;
            end
        end
    endtask

    initial begin
        forever begin
            @(posedge clk);
            #1;
            mon(0, lvl0, rise0, fall0);
            mon(1, lvl1, rise1, fall1);
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: bench did not complete");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int unsigned t0;
        int unsigned p0;
        bit          reached;

        rst = 1'b0;
        en  = 1'b1;
        b0  = '0;
        b1  = '1;
        repeat (5) @(negedge clk);
        rst = 1'b1;
        repeat (20) @(negedge clk);
        check("idle_level0", {30'd0, lvl0}, 32'd0);
        check("idle_level1", {30'd0, lvl1}, 32'd0);
        check("idle_no_pulse_inv", pulses1, 32'd0);

        // Clean press on channel 0
        t0    = cyc;
        b0[0] = 1'b1;
        repeat (100) @(negedge clk);
        check("press_level", {30'd0, lvl0}, 32'd1);
        check("press_one_rise", rise_cnt0, 32'd1);
        check_range("press_latency", last_rise_cyc0 - t0, 2 + (STABLE - 1) * DIV + 1, 2 + STABLE * DIV);

        // Release
        b0[0] = 1'b0;
        repeat (40) @(negedge clk);
        check("release_level", {30'd0, lvl0}, 32'd0);
        check("release_one_fall", fall_cnt0, 32'd1);

        // Glitch of two ticks
        p0    = pulses0;
        b0[0] = 1'b1;
        repeat (20) @(negedge clk);
        b0[0] = 1'b0;
        repeat (60) @(negedge clk);
        check("glitch_level", {30'd0, lvl0}, 32'd0);
        check("glitch_no_pulse", pulses0, p0);
        check("glitch_counter_cleared", {30'd0, dut0.g_ch[0].cnt}, 32'd0);

        // Simultaneous press on both channels
        b0 = 2'b11;
        repeat (50) @(negedge clk);
        check("simul_rise_vec", {30'd0, last_rise_vec0}, 32'd3);
        check("simul_level", {30'd0, lvl0}, 32'd3);
        b0 = 2'b00;
        repeat (50) @(negedge clk);
        check("simul_release_level", {30'd0, lvl0}, 32'd0);

        // Enable gating
        en    = 1'b0;
        b0[0] = 1'b1;
        repeat (200) @(negedge clk);
        check("en_off_hold", {30'd0, lvl0}, 32'd0);
        en = 1'b1;
        repeat (STABLE * DIV) @(posedge clk);
        #1;
        check("en_on_level", {30'd0, lvl0}, 32'd1);
        @(negedge clk);
        b0[0] = 1'b0;
        repeat (40) @(negedge clk);
        check("en_release_level", {30'd0, lvl0}, 32'd0);

        // Reset after two disagreeing ticks
        b0[0]   = 1'b1;
        reached = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (run[0][0] == 2) begin
                reached = 1'b1;
                break;
            end
        end
        if (!reached) fail("reset_mid_timeout", 32'd0, 32'd1);
        rst = 1'b0;
        repeat (5) @(negedge clk);
        check("reset_mid_outputs0", {26'd0, lvl0, rise0, fall0}, 32'd0);
        check("reset_mid_outputs1", {26'd0, lvl1, rise1, fall1}, 32'd0);
        t0  = cyc;
        rst = 1'b1;
        repeat (40) @(negedge clk);
        check("reset_fresh_rise_latency", last_rise_cyc0 - t0, STABLE * DIV);
        check("reset_fresh_level", {30'd0, lvl0}, 32'd1);
        b0[0] = 1'b0;
        repeat (40) @(negedge clk);

        // Active-low polarity on the inverted instance
        b1[0] = 1'b0;
        repeat (50) @(negedge clk);
        check("inv_level", {30'd0, lvl1}, 32'd1);
        check("inv_rise_vec", {30'd0, last_rise_vec1}, 32'd1);
        b1[0] = 1'b1;
        repeat (50) @(negedge clk);
        check("inv_release_level", {30'd0, lvl1}, 32'd0);

        // Randomized bouncing, holds and enable drops
        for (int i = 0; i < 25; i++) begin
            b0 = N'($urandom_range(0, 3));
            b1 = N'($urandom_range(0, 3));
            en = ($urandom_range(0, 4) != 0);
            repeat ($urandom_range(5, 45)) @(negedge clk);
        end
        en = 1'b1;
        repeat (80) @(negedge clk);
        check("final_queue0_empty", exp_q0.size(), 32'd0);
        check("final_queue1_empty", exp_q1.size(), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
